// File: rtl/count_display_scan_if.sv
// Connection between the up/down counter and the display scanner: the count,
// the event pulses and the multiplexed 7-segment drive lines.
interface count_display_scan_if;
  logic [3:0] num;
  logic       upbuttonFlag;
  logic       downbuttonFlag;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output num, upbuttonFlag, downbuttonFlag,
    input  an, seg, dp
  );

  modport slave (
    input  num, upbuttonFlag, downbuttonFlag,
    output an, seg, dp
  );
endinterface

// File: rtl/count_display_scan.sv
// Drives a 4-digit common-anode multiplexed 7-segment display with the count,
// the direction of the last button event and a running total of events.
module count_display_scan #(
  parameter logic [27:0] clk_freq   = 28'd10_000_000,
  parameter logic [27:0] scan_freq  = 28'd1000,
  parameter logic [7:0]  hold_scans = 8'd200
) (
  input logic                 sys_clk_in,
  input logic                 reset,
  count_display_scan_if.slave disp
);

  localparam int unsigned SLOT  = int'(clk_freq / scan_freq);
  localparam int unsigned DIV_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SLOT - 1);

  localparam logic [6:0] GLYPH_U     = 7'h41;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_t;
  typedef enum logic [1:0] {IND_IDLE, IND_UP, IND_DOWN} ind_t;

  logic [DIV_W-1:0] divider;
  slot_t            slot;
  logic [7:0]       press_cnt;
  ind_t             indicator;
  logic [7:0]       hold;

  logic       tick_c;
  logic       frame_end_c;
  logic       up_only_c;
  logic       down_only_c;
  logic       both_c;
  logic [6:0] glyph_c;
  logic [3:0] an_sel_c;
  slot_t      slot_next_c;

  // Active-low hex digit patterns, {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_c      = (divider == DIV_MAX);
    frame_end_c = tick_c && (slot == DIG3);
    up_only_c   = disp.upbuttonFlag && !disp.downbuttonFlag;
    down_only_c = disp.downbuttonFlag && !disp.upbuttonFlag;
    both_c      = disp.upbuttonFlag && disp.downbuttonFlag;
    slot_next_c = slot;
    an_sel_c    = 4'hF;
    glyph_c     = GLYPH_BLANK;
    case (slot)
      DIG0: begin
        slot_next_c = DIG1;
        an_sel_c    = 4'b1110;
        glyph_c     = hex7(disp.num);
      end
      DIG1: begin
        slot_next_c = DIG2;
        an_sel_c    = 4'b1101;
        case (indicator)
          IND_UP:   glyph_c = GLYPH_U;
          IND_DOWN: glyph_c = GLYPH_D;
          default:  glyph_c = GLYPH_DASH;
        endcase
      end
      DIG2: begin
        slot_next_c = DIG3;
        an_sel_c    = 4'b1011;
        glyph_c     = hex7(press_cnt[3:0]);
      end
      default: begin
        slot_next_c = DIG0;
        an_sel_c    = 4'b0111;
        glyph_c     = hex7(press_cnt[7:4]);
      end
    endcase
  end

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      divider   <= '0;
      slot      <= DIG0;
      press_cnt <= 8'h00;
      indicator <= IND_IDLE;
      hold      <= 8'h00;
      disp.an   <= 4'hF;
      disp.seg  <= GLYPH_BLANK;
      disp.dp   <= 1'b1;
    end else begin
      divider <= tick_c ? '0 : DIV_W'(divider + DIV_W'(1));
      if (tick_c) slot <= slot_next_c;

      if (both_c)                        press_cnt <= 8'(press_cnt + 8'd2);
      else if (up_only_c || down_only_c) press_cnt <= 8'(press_cnt + 8'd1);

      // A single event reloads the hold and beats a coincident frame-end decrement
      if (up_only_c) begin
        indicator <= IND_UP;
        hold      <= hold_scans;
      end else if (down_only_c) begin
        indicator <= IND_DOWN;
        hold      <= hold_scans;
      end else if (frame_end_c) begin
        if (hold != 8'h00) hold <= 8'(hold - 8'd1);
        if (hold <= 8'h01) indicator <= IND_IDLE;
      end

      // First cycle of each slot is blanked to avoid ghosting between digits
      disp.an  <= (divider == '0) ? 4'hF : an_sel_c;
      disp.seg <= glyph_c;
      disp.dp  <= !((slot == DIG1) && (divider != '0) && (hold != 8'h00));
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan: walks whole display frames and checks
// digit enables, segments and decimal point against hand-computed glyphs.
module tb_count_display_scan;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   k;

  count_display_scan_if bus ();

  count_display_scan #(
    .clk_freq  (28'd10_000_000),
    .scan_freq (28'd1_000_000),
    .hold_scans(8'd2)
  ) dut (
    .sys_clk_in(clk),
    .reset     (rst),
    .disp      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d): got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  // One clock; k counts edges since reset release, outputs sampled at the negedge
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic step_check(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3, input bit dp_on);
    int s;
    int d;
    logic [6:0] g;
    logic [3:0] ea;
    step();
    d  = (k - 1) % 10;
    s  = ((k - 1) / 10) % 4;
    ea = (d == 0) ? 4'hF : 4'(~(4'b0001 << s));
    case (s)
      0:       g = g0;
      1:       g = g1;
      2:       g = g2;
      default: g = g3;
    endcase
    check($sformatf("%s.an", tag), 32'(bus.an), 32'(ea));
    check($sformatf("%s.dp", tag), 32'(bus.dp), (s == 1 && d != 0 && dp_on) ? 32'd0 : 32'd1);
    if (d != 0) check($sformatf("%s.seg%0d", tag, s), 32'(bus.seg), 32'(g));
  endtask

  // Full 40-cycle frame; optional flags are pulsed for the first cycle only
  task automatic run_frame(input string tag, input bit up, input bit dn,
                           input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3, input bit dp_on);
    bus.upbuttonFlag   = up;
    bus.downbuttonFlag = dn;
    step_check(tag, g0, g1, g2, g3, dp_on);
    bus.upbuttonFlag   = 1'b0;
    bus.downbuttonFlag = 1'b0;
    for (int i = 1; i < 40; i++) step_check(tag, g0, g1, g2, g3, dp_on);
  endtask

  // Holds both flags for n cycles, then idles to the next frame boundary
  task automatic burst_both(input int n);
    bus.upbuttonFlag   = 1'b1;
    bus.downbuttonFlag = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.upbuttonFlag   = 1'b0;
    bus.downbuttonFlag = 1'b0;
    while (k % 40 != 0) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k      = 0;
    rst    = 1'b1;
    bus.num            = 4'h5;
    bus.upbuttonFlag   = 1'b0;
    bus.downbuttonFlag = 1'b0;

    // T1: reset values, then blank first cycle and DIG0 from the second
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.an", 32'(bus.an), 32'h0F);
    check("rst.seg", 32'(bus.seg), 32'h7F);
    check("rst.dp", 32'(bus.dp), 32'd1);
    rst = 1'b0;
    k   = 0;

    // T2: steady num=5, idle indicator, zero total, 40-cycle frames
    run_frame("A", 0, 0, 7'h12, 7'h3F, 7'h40, 7'h40, 0);
    run_frame("B", 0, 0, 7'h12, 7'h3F, 7'h40, 7'h40, 0);

    // T3: up pulse shows 'U' with dp for two frames, then reverts to '-'
    run_frame("C", 1, 0, 7'h12, 7'h41, 7'h79, 7'h40, 1);
    run_frame("D", 0, 0, 7'h12, 7'h41, 7'h79, 7'h40, 1);
    run_frame("E", 0, 0, 7'h12, 7'h3F, 7'h79, 7'h40, 0);

    // T4: down while UP reloads the hold (lasts two more frames)
    run_frame("F", 1, 0, 7'h12, 7'h41, 7'h24, 7'h40, 1);
    run_frame("G", 0, 1, 7'h12, 7'h21, 7'h30, 7'h40, 1);
    run_frame("H", 0, 0, 7'h12, 7'h21, 7'h30, 7'h40, 1);
    run_frame("I", 0, 0, 7'h12, 7'h3F, 7'h30, 7'h40, 0);

    // T5: total 03 + 2*125 = FD, then up to FE, FF, then both wraps to 01
    burst_both(125);
    run_frame("J", 1, 0, 7'h12, 7'h41, 7'h06, 7'h0E, 1);
    run_frame("K", 1, 0, 7'h12, 7'h41, 7'h0E, 7'h0E, 1);
    run_frame("L", 1, 1, 7'h12, 7'h41, 7'h79, 7'h40, 1);
    bus.num = 4'hA;
    run_frame("M", 0, 0, 7'h08, 7'h3F, 7'h79, 7'h40, 0);

    // T6: build total 3A, then reset in the middle of the DIG2 slot
    burst_both(28);
    run_frame("N", 1, 0, 7'h08, 7'h41, 7'h08, 7'h30, 1);
    for (int i = 0; i < 25; i++) step_check("O", 7'h08, 7'h41, 7'h08, 7'h30, 1);
    rst = 1'b1;
    step();
    check("midrst.an", 32'(bus.an), 32'h0F);
    check("midrst.seg", 32'(bus.seg), 32'h7F);
    check("midrst.dp", 32'(bus.dp), 32'd1);
    rst = 1'b0;
    k   = 0;
    run_frame("P", 0, 0, 7'h08, 7'h3F, 7'h40, 7'h40, 0);
    bus.num = 4'h7;
    run_frame("Q", 0, 0, 7'h78, 7'h3F, 7'h40, 7'h40, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
